fetch_unit_l5: RTL

FETCH_UNIT_L5 -- requirements
Module: fetch_unit_l5

---
 rtl/fetch_unit_l5_pkg.sv | 32 +++
 rtl/fetch_buffer.sv | 81 ++++++++
 rtl/fetch_unit_l5.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_l5_pkg.sv
// Shared fetch definitions: memory request/response shapes, buffer entry layout
// and sequence-number age arithmetic used by the fetch unit and its buffer.
package fetch_unit_l5_pkg;

    localparam logic [31:0] P_RST_ADDR = 32'h0000_0200;

    // Drop counter width; sized well above any realistic number of abandoned requests.
    localparam int unsigned DROP_W = 8;

    typedef struct packed {
        logic [31:0] addr;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] data;
    } mem_resp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Distance from older to younger in a wrapping sequence space of 'bits' bits.
    function automatic logic [31:0] seq_age(input logic [31:0] younger,
                                            input logic [31:0] older,
                                            input int unsigned bits);
        logic [31:0] mask;
        mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        return (younger - older) & mask;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular fetch buffer: entries are reserved when a request is accepted, filled
// in order as responses return, and popped from the head once they hold data.
module fetch_buffer
    import fetch_unit_l5_pkg::*;
#(
    parameter  int unsigned p_depth = 2,
    localparam int unsigned AW      = $clog2(p_depth),
    localparam int unsigned CW      = $clog2(p_depth) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          reserve,
    input  logic [31:0]   reserve_pc,
    input  logic          fill,
    input  logic [31:0]   fill_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] pend_cnt,
    output logic          head_valid,
    output fetch_entry_t  head
);

    logic [AW-1:0]      head_ptr;
    logic [AW-1:0]      tail_ptr;
    logic [AW-1:0]      fill_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      pend_q;
    logic [p_depth-1:0] data_valid;
    fetch_entry_t       entries [p_depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            fill_ptr   <= '0;
            count      <= '0;
            pend_q     <= '0;
            data_valid <= '0;
        end else if (flush) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            fill_ptr   <= '0;
            count      <= '0;
            pend_q     <= '0;
            data_valid <= '0;
        end else begin
            if (reserve) begin
                data_valid[tail_ptr] <= 1'b0;
                tail_ptr             <= tail_ptr + AW'(1);
            end
            // A fill may land on the entry reserved this same cycle; the later write wins.
            if (fill) begin
                data_valid[fill_ptr] <= 1'b1;
                fill_ptr             <= fill_ptr + AW'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + AW'(1);
            end
            count  <= count + CW'(reserve) - CW'(pop);
            pend_q <= pend_q + CW'(reserve) - CW'(fill);
        end
    end

    always_ff @(posedge clk) begin
        if (reserve && !flush) begin
            entries[tail_ptr].pc <= reserve_pc;
        end
        if (fill && !flush) begin
            entries[fill_ptr].inst <= fill_data;
        end
    end

    assign full       = (count == CW'(p_depth));
    assign empty      = (count == '0);
    assign pend_cnt   = pend_q;
    assign head_valid = data_valid[head_ptr];
    assign head       = entries[head_ptr];

endmodule

// File: rtl/fetch_unit_l5.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses, hands instructions to decode with sequence numbers, and redirects on squash.
module fetch_unit_l5
    import fetch_unit_l5_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = 5,
    parameter logic [31:0] p_rst_addr     = P_RST_ADDR,
    parameter int unsigned p_buf_depth    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [31:0]               mem_req_addr,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  logic [31:0]               mem_resp_data,
    output logic                      d_val,
    input  logic                      d_rdy,
    output logic [31:0]               d_inst,
    output logic [31:0]               d_pc,
    output logic [p_seq_num_bits-1:0] d_seq_num,
    input  logic                      squash_val,
    input  logic [31:0]               squash_target,
    input  logic [p_seq_num_bits-1:0] squash_seq_num,
    input  logic                      commit_val,
    input  logic [p_seq_num_bits-1:0] commit_seq_num
);

    localparam int unsigned SW        = p_seq_num_bits;
    localparam int unsigned CW        = $clog2(p_buf_depth) + 1;
    localparam logic [31:0] SEQ_LIMIT = (32'd1 << SW) - 32'd1;

    logic              run_q;
    logic [31:0]       fetch_pc;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_total;
    logic [DROP_W-1:0] drop_on_squash;
    logic              drop_ok;
    logic [SW-1:0]     seq_next;
    logic [SW-1:0]     seq_oldest;
    logic [31:0]       in_flight;
    logic              inflight_ok;

    logic              buf_full;
    logic              buf_empty;
    logic              head_valid;
    fetch_entry_t      head;
    logic [CW-1:0]     pend_cnt;

    logic              req_fire;
    logic              resp_drop;
    logic              resp_fill;
    logic              pop;
    mem_req_t          req;
    mem_resp_t         resp;
    logic              unused_inputs;

    assign in_flight   = seq_age(32'(seq_next), 32'(seq_oldest), SW);
    assign inflight_ok = (in_flight < SEQ_LIMIT);

    // Stop issuing once half the drop range is consumed so a later squash cannot overflow it.
    assign drop_ok = !drop_cnt[DROP_W-1];

    // run_q holds requests off while reset is asserted and for the cycle it releases.
    assign mem_req_val  = run_q && !buf_full && !squash_val && drop_ok;
    assign req.addr     = fetch_pc;
    assign mem_req_addr = req.addr;
    assign req_fire     = mem_req_val && mem_req_rdy;

    assign mem_resp_rdy = 1'b1;
    assign resp.data    = mem_resp_data;
    assign resp_drop    = mem_resp_val && (drop_cnt != '0);
    assign resp_fill    = mem_resp_val && (drop_cnt == '0) && !squash_val
                          && ((pend_cnt != '0) || req_fire);

    assign d_val     = !buf_empty && head_valid && !squash_val && inflight_ok;
    assign d_inst    = head.inst;
    assign d_pc      = head.pc;
    assign d_seq_num = seq_next;
    assign pop       = d_val && d_rdy;

    // Everything still owed by memory, minus a response that lands in the squash cycle.
    assign drop_total     = drop_cnt + DROP_W'(pend_cnt);
    assign drop_on_squash = (mem_resp_val && (drop_total != '0)) ? drop_total - DROP_W'(1)
                                                                 : drop_total;

    assign unused_inputs = ^{commit_seq_num, squash_target[1:0]};

    fetch_buffer #(
        .p_depth(p_buf_depth)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (squash_val),
        .reserve   (req_fire),
        .reserve_pc(fetch_pc),
        .fill      (resp_fill),
        .fill_data (resp.data),
        .pop       (pop),
        .full      (buf_full),
        .empty     (buf_empty),
        .pend_cnt  (pend_cnt),
        .head_valid(head_valid),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            fetch_pc   <= p_rst_addr;
            drop_cnt   <= '0;
            seq_next   <= '0;
            seq_oldest <= '0;
        end else begin
            run_q <= 1'b1;
            if (squash_val) begin
                fetch_pc <= {squash_target[31:2], 2'b00};
                drop_cnt <= drop_on_squash;
                seq_next <= squash_seq_num + SW'(1);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - DROP_W'(1);
                end
                if (pop) begin
                    seq_next <= seq_next + SW'(1);
                end
            end
            if (commit_val) begin
                seq_oldest <= seq_oldest + SW'(1);
            end
        end
    end

endmodule
